// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wave_pkg
// Description : Shared widths, bank size and FSM state type for the wavetable
//               bank writer/reader pair.
// Revision    : 1.0 - initial release
// ============================================================================
package wave_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int BANK_W     = 4;
    localparam int BANK_WORDS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STALL   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wave_bank_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : wave_bank_reader_if
// Description : Control, RAM read port and sample output bundle of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_bank_reader_if;
    import wave_pkg::*;

    logic              enable;
    logic [BANK_W-1:0] WBANK;
    logic              SAMPLE_TICK;
    logic              RD_EN;
    logic [BANK_W-1:0] RBANK;
    logic [ADDR_W-1:0] RADDR;
    logic [DATA_W-1:0] RDATA;
    logic [DATA_W-1:0] SAMPLE;
    logic              SAMPLE_VALID;
    logic              BANK_DONE;
    logic              UNDERRUN;

    modport master (
        input  enable, WBANK, SAMPLE_TICK, RDATA,
        output RD_EN, RBANK, RADDR, SAMPLE, SAMPLE_VALID, BANK_DONE, UNDERRUN
    );

    modport slave (
        output enable, WBANK, SAMPLE_TICK, RDATA,
        input  RD_EN, RBANK, RADDR, SAMPLE, SAMPLE_VALID, BANK_DONE, UNDERRUN
    );

endinterface
`default_nettype wire

// File: rtl/wave_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : wave_addr_ctr
// Description : Bank + address counter; address wraps into the next bank.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_addr_ctr
    import wave_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              adv_i,
    output logic [BANK_W-1:0]      bank_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [BANK_W-1:0]      bank_next_o,
    output logic                   addr_last_o
);

    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;

    assign bank_o      = bank_q;
    assign addr_o      = addr_q;
    assign bank_next_o = bank_q + 1'b1;
    assign addr_last_o = (addr_q == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
            addr_q <= '0;
        end else if (adv_i) begin
            if (addr_last_o) begin
                addr_q <= '0;
                bank_q <= bank_next_o;
            end else begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wave_bank_reader.sv
`default_nettype none
// ============================================================================
// Module      : wave_bank_reader
// Description : Streams wave RAM samples one bank behind the writer, one per
//               SAMPLE_TICK, flagging underrun when it catches the writer.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_bank_reader
    import wave_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    wave_bank_reader_if.master bus
);

    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic              rd_en_q;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              sample_valid_q, sample_valid_d;
    logic              bank_done_q, bank_done_d;
    logic              underrun_q, underrun_d;
    logic              adv;
    logic [BANK_W-1:0] rbank, bank_next;
    logic [ADDR_W-1:0] raddr;
    logic              addr_last;

    wave_addr_ctr u_ctr (
        .clk         (clk),
        .rst         (rst),
        .adv_i       (adv),
        .bank_o      (rbank),
        .addr_o      (raddr),
        .bank_next_o (bank_next),
        .addr_last_o (addr_last)
    );

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        bank_done_d    = 1'b0;
        underrun_d     = underrun_q;
        adv            = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;
                if (bus.enable && (bus.WBANK != rbank))
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.SAMPLE_TICK || pending_q) begin
                    state_d   = ST_READ;
                    pending_d = 1'b0;
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
                if (bus.SAMPLE_TICK)
                    pending_d = 1'b1;
            end
            ST_CAPTURE: begin
                sample_d       = bus.RDATA;
                sample_valid_d = 1'b1;
                adv            = 1'b1;
                state_d        = ST_ARMED;
                if (bus.SAMPLE_TICK)
                    pending_d = 1'b1;
                if (addr_last) begin
                    bank_done_d = 1'b1;
                    if (bank_next == bus.WBANK) begin
                        state_d    = ST_STALL;
                        underrun_d = 1'b1;
                        pending_d  = 1'b0;
                    end
                end
            end
            ST_STALL: begin
                pending_d = 1'b0;
                if (bus.WBANK != rbank)
                    state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable parks in IDLE; a capture in flight still delivers its sample
        // and advances, but a wrap here is not a stall on the writer.
        if (!bus.enable) begin
            state_d    = ST_IDLE;
            pending_d  = 1'b0;
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            rd_en_q        <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            bank_done_q    <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            rd_en_q        <= (state_d == ST_READ);
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            bank_done_q    <= bank_done_d;
            underrun_q     <= underrun_d;
        end
    end

    assign bus.RD_EN        = rd_en_q;
    assign bus.RBANK        = rbank;
    assign bus.RADDR        = raddr;
    assign bus.SAMPLE       = sample_q;
    assign bus.SAMPLE_VALID = sample_valid_q;
    assign bus.BANK_DONE    = bank_done_q;
    assign bus.UNDERRUN     = underrun_q;

endmodule
`default_nettype wire
